dmem_access_unit: RTL

Memory-stage data access controller that sits directly downstream of the execute stage and its EX/MEM register. It consumes ALUResultM, WriteDataM and the M-stage memory control bits, and drives a variable-latency data memory over a req/ack handshake. It returns formatted load data as ReadDataM to the MEM/WB register. While an access is outstanding it asserts StallM to the hazard unit. It supports word and byte (LDRB/STRB) accesses, detects misaligned word accesses, and times out memories that never respond.

---
 rtl/dmem_access_unit.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/dmem_access_unit.sv
// Memory-stage data access controller: drives a req/ack data memory for word and
// byte loads/stores, stalls the pipeline while busy, and flags misalignment or timeout.
module dmem_access_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReqM,
  input  logic        MemWriteM,
  input  logic        ByteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        MemFault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic        byte_q;
  logic [1:0]  lane_q;
  logic [31:0] rdata_q;
  logic        fault_q;
  logic        req_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;

  logic        misaligned_d;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] rdata_fmt_d;

  function automatic logic [3:0] byte_enables(input logic byte_acc, input logic [1:0] lane);
    logic [3:0] be;
    be = 4'hF;
    if (byte_acc) be = 4'b0001 << lane;
    return be;
  endfunction

  function automatic logic [31:0] store_format(input logic byte_acc, input logic [31:0] data);
    logic [31:0] wd;
    wd = data;
    if (byte_acc) wd = {4{data[7:0]}};
    return wd;
  endfunction

  // Byte loads zero-extend the lane selected by the original low address bits.
  function automatic logic [31:0] load_format(input logic byte_acc, input logic [1:0] lane,
                                              input logic [31:0] word);
    logic [31:0] rd;
    rd = word;
    if (byte_acc) begin
      case (lane)
        2'd0:    rd = {24'h0, word[7:0]};
        2'd1:    rd = {24'h0, word[15:8]};
        2'd2:    rd = {24'h0, word[23:16]};
        default: rd = {24'h0, word[31:24]};
      endcase
    end
    return rd;
  endfunction

  always_comb begin
    misaligned_d = !ByteM && (ALUResultM[1:0] != 2'b00);
    be_d         = byte_enables(ByteM, ALUResultM[1:0]);
    wdata_d      = store_format(ByteM, WriteDataM);
    rdata_fmt_d  = load_format(byte_q, lane_q, mem_rdata);
  end

  // The stall is combinational in IDLE so the request cycle itself holds the pipeline.
  always_comb begin
    StallM = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE:    StallM = MemReqM;
        BUSY:    StallM = 1'b1;
        default: StallM = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      byte_q  <= 1'b0;
      lane_q  <= 2'd0;
      rdata_q <= 32'd0;
      fault_q <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          fault_q <= 1'b0;
          if (MemReqM) begin
            if (misaligned_d) begin
              state_q <= DONE;
              fault_q <= 1'b1;
              rdata_q <= 32'd0;
            end else begin
              state_q <= BUSY;
              req_q   <= 1'b1;
              we_q    <= MemWriteM;
              addr_q  <= {ALUResultM[31:2], 2'b00};
              wdata_q <= wdata_d;
              be_q    <= be_d;
              byte_q  <= ByteM;
              lane_q  <= ALUResultM[1:0];
              cnt_q   <= 8'd0;
            end
          end
        end
        BUSY: begin
          // An ack in the final timeout cycle takes priority over the fault.
          if (mem_ack) begin
            req_q   <= 1'b0;
            state_q <= DONE;
            if (!we_q) rdata_q <= rdata_fmt_d;
          end else if (cnt_q == CNT_LAST) begin
            req_q   <= 1'b0;
            fault_q <= 1'b1;
            rdata_q <= 32'd0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: begin
          fault_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ReadDataM = rdata_q;
  assign MemFault  = fault_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;

endmodule
